// File: rtl/acu_pkg.sv
// Shared opcodes, ACU selects and FSM encoding for the
// accumulate/multiply sequencer.
package acu_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_MUL   = 2'b01;
  localparam logic [1:0] OP_MAC   = 2'b10;
  localparam logic [1:0] OP_LDACC = 2'b11;

  localparam logic [3:0] SEL_ADD = 4'd0;
  localparam logic [3:0] SEL_MUL = 4'd1;
  localparam logic [3:0] SEL_MAC = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC1,
    S_EXEC2,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

endpackage

// File: rtl/acu_mac_seq_acu.sv
// Arithmetic core: wide adder and squaring multiplier
// selected by sel_i.
module acu_mac_seq_acu
  import acu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] acc_i,
  input  logic [3:0]  sel_i,
  output logic [32:0] xsum_o,
  output logic [31:0] xprod_o
);

  logic [31:0] sq;

  assign sq = a_i * a_i;

  always_comb begin
    xsum_o  = '0;
    xprod_o = '0;
    unique case (sel_i)
      SEL_ADD: xsum_o = {1'b0, a_i} + {1'b0, b_i};
      SEL_MUL: xprod_o = sq;
      SEL_MAC: begin
        xprod_o = sq;
        xsum_o  = {1'b0, acc_i} + {1'b0, sq};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acu_mac_seq.sv
// Command sequencer around the ACU: ADD, MUL (square),
// MAC into accumulator, and accumulator load.
module acu_mac_seq
  import acu_pkg::*;
#(
  parameter bit SAT_EN = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_carry_o,
  output logic [31:0] acc_o,
  output logic        busy_o
);

  state_e      state_q;
  cmd_t        cmd_q;
  logic [31:0] acc_q;
  logic [31:0] prod_q;
  logic [31:0] rsp_data_q;
  logic        rsp_carry_q;

  logic [31:0] acu_a;
  logic [31:0] acu_b;
  logic [3:0]  acu_sel;
  logic [32:0] xsum;
  logic [31:0] xprod;

  // ACU operands come only from registered state.
  always_comb begin
    acu_a   = '0;
    acu_b   = '0;
    acu_sel = SEL_ADD;
    unique case (state_q)
      S_EXEC1: begin
        unique case (cmd_q.op)
          OP_ADD: begin
            acu_a = cmd_q.a;
            acu_b = cmd_q.b;
          end
          OP_MUL, OP_MAC: begin
            acu_a   = cmd_q.a;
            acu_sel = SEL_MUL;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        acu_a = prod_q;
        acu_b = acc_q;
      end
      default: ;
    endcase
  end

  acu_mac_seq_acu u_acu (
    .a_i    (acu_a),
    .b_i    (acu_b),
    .acc_i  (acc_q),
    .sel_i  (acu_sel),
    .xsum_o (xsum),
    .xprod_o(xprod)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            cmd_q   <= '{op: cmd_op_i, a: cmd_a_i, b: cmd_b_i};
            state_q <= S_EXEC1;
          end
        end
        S_EXEC1: begin
          unique case (cmd_q.op)
            OP_ADD: begin
              rsp_data_q  <= xsum[31:0];
              rsp_carry_q <= xsum[32];
              state_q     <= S_RESP;
            end
            OP_MUL: begin
              rsp_data_q  <= xprod;
              rsp_carry_q <= 1'b0;
              state_q     <= S_RESP;
            end
            OP_MAC: begin
              prod_q  <= xprod;
              state_q <= S_EXEC2;
            end
            default: begin
              acc_q       <= cmd_q.a;
              rsp_data_q  <= cmd_q.a;
              rsp_carry_q <= 1'b0;
              state_q     <= S_RESP;
            end
          endcase
        end
        S_EXEC2: begin
          if (SAT_EN && xsum[32]) begin
            acc_q      <= 32'hFFFF_FFFF;
            rsp_data_q <= 32'hFFFF_FFFF;
          end else begin
            acc_q      <= xsum[31:0];
            rsp_data_q <= xsum[31:0];
          end
          rsp_carry_q <= xsum[32];
          state_q     <= S_RESP;
        end
        default: begin
          if (rsp_ready_i) state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake flags are forced low while reset is held.
  assign cmd_ready_o = rst_ni && (state_q == S_IDLE);
  assign rsp_valid_o = rst_ni && (state_q == S_RESP);
  assign busy_o      = rst_ni && (state_q != S_IDLE);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_carry_o = rsp_carry_q;
  assign acc_o       = acc_q;

endmodule

// File: tb/tb_acu_mac_seq.sv
// Directed bench for acu_mac_seq; a wrapping and a
// saturating instance share one stimulus stream.
module tb_acu_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        rsp_ready;

  logic        rdy0, vld0, car0, bsy0;
  logic [31:0] dat0, acc0;
  logic        rdy1, vld1, car1, bsy1;
  logic [31:0] dat1, acc1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  acu_mac_seq #(.SAT_EN(1'b0)) dut0 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(rdy0),
    .cmd_op_i   (cmd_op),
    .cmd_a_i    (cmd_a),
    .cmd_b_i    (cmd_b),
    .rsp_valid_o(vld0),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (dat0),
    .rsp_carry_o(car0),
    .acc_o      (acc0),
    .busy_o     (bsy0)
  );

  acu_mac_seq #(.SAT_EN(1'b1)) dut1 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(rdy1),
    .cmd_op_i   (cmd_op),
    .cmd_a_i    (cmd_a),
    .cmd_b_i    (cmd_b),
    .rsp_valid_o(vld1),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (dat1),
    .rsp_carry_o(car1),
    .acc_o      (acc1),
    .busy_o     (bsy1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a command, check latency, stop in RESP.
  task automatic do_cmd(input string tag,
                        input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int lat,
                        input logic [31:0] exp_d,
                        input logic exp_c);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    tick();
    cmd_valid = 1'b0;
    check({tag, "_busy"}, 32'(bsy0), 32'd1);
    check({tag, "_early"}, 32'(vld0), 32'd0);
    for (int i = 2; i < lat; i++) begin
      tick();
      check({tag, "_early"}, 32'(vld0), 32'd0);
    end
    tick();
    check({tag, "_valid"}, 32'(vld0), 32'd1);
    check({tag, "_valid1"}, 32'(vld1), 32'd1);
    check({tag, "_data"}, dat0, exp_d);
    check({tag, "_carry"}, 32'(car0), 32'(exp_c));
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("ack_valid", 32'(vld0), 32'd0);
    check("ack_ready", 32'(rdy0), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(rdy0), 32'd0);
    check("rst_busy", 32'(bsy0), 32'd0);
    check("rst_valid", 32'(vld0), 32'd0);
    check("rst_acc", acc0, 32'd0);
    check("rst_data", dat0, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(rdy0), 32'd1);

    do_cmd("add", 2'b00, 32'd5, 32'd7, 2, 32'd12, 1'b0);
    ack();

    do_cmd("ld10", 2'b11, 32'd10, 32'd0, 2, 32'd10, 1'b0);
    ack();
    check("ld10_acc", acc0, 32'd10);

    do_cmd("mul", 2'b01, 32'd3, 32'd0, 2, 32'd9, 1'b0);
    check("mul_acc", acc0, 32'd10);
    ack();

    do_cmd("mac3", 2'b10, 32'd3, 32'd0, 3, 32'd19, 1'b0);
    ack();
    do_cmd("mac2", 2'b10, 32'd2, 32'd0, 3, 32'd23, 1'b0);
    ack();
    check("mac_acc", acc0, 32'd23);
    check("mac_acc1", acc1, 32'd23);

    // Backpressure with a command waiting behind it.
    do_cmd("bp", 2'b00, 32'd1, 32'd2, 2, 32'd3, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_a     = 32'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(vld0), 32'd1);
      check("bp_data", dat0, 32'd3);
      check("bp_ready", 32'(rdy0), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_hs_ready", 32'(rdy0), 32'd1);
    check("bp_hs_busy", 32'(bsy0), 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("bp_acc_busy", 32'(bsy0), 32'd1);
    check("bp_acc_valid", 32'(vld0), 32'd0);
    tick();
    check("bp_mul_valid", 32'(vld0), 32'd1);
    check("bp_mul_data", dat0, 32'd16);
    ack();

    // Overflow: wrap on dut0, saturate on dut1.
    do_cmd("ldff", 2'b11, 32'hFFFF_FFFE, 32'd0, 2,
           32'hFFFF_FFFE, 1'b0);
    ack();
    do_cmd("ovf", 2'b10, 32'd2, 32'd0, 3, 32'd2, 1'b1);
    check("ovf_acc", acc0, 32'd2);
    check("sat_data", dat1, 32'hFFFF_FFFF);
    check("sat_carry", 32'(car1), 32'd1);
    check("sat_acc", acc1, 32'hFFFF_FFFF);
    ack();

    // Reset during EXEC2 of a MAC.
    do_cmd("ld5", 2'b11, 32'd5, 32'd0, 2, 32'd5, 1'b0);
    ack();
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_a     = 32'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mrst_busy", 32'(bsy0), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mrst_ready", 32'(rdy0), 32'd0);
    check("mrst_valid", 32'(vld0), 32'd0);
    check("mrst_busyr", 32'(bsy0), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mrst_rel_ready", 32'(rdy0), 32'd1);
    check("mrst_acc", acc0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_norsp", 32'(vld0), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acu_mac_seq.md
ACU_MAC_SEQ -- requirements
Module: acu_mac_seq

Interface
REQ-001 The block SHALL have parameter SAT_EN, default 0; when 1, MAC overflow saturates the accumulator.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port cmd_valid_i, input, 1, command request.
REQ-005 The block SHALL have port cmd_ready_o, output, 1, command accept.
REQ-006 The block SHALL have port cmd_op_i, input, 2, opcode: 00 ADD, 01 MUL, 10 MAC, 11 LDACC.
REQ-007 The block SHALL have ports cmd_a_i and cmd_b_i, input, 32 each, operands.
REQ-008 The block SHALL have port rsp_valid_o, output, 1, result available.
REQ-009 The block SHALL have port rsp_ready_i, input, 1, result consumed.
REQ-010 The block SHALL have port rsp_data_o, output, 32, result.
REQ-011 The block SHALL have port rsp_carry_o, output, 1, adder carry-out (bit 32 of ACU sum).
REQ-012 The block SHALL have port acc_o, output, 32, current accumulator value.
REQ-013 The block SHALL have port busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC1, EXEC2, RESP; cmd_ready_o = (state == IDLE).
REQ-015 In IDLE with cmd_valid_i=1, the block SHALL latch op, a and b into registers and go to EXEC1.
REQ-016 The ACU inputs (A, B, Acc, Sel) SHALL be driven only from registers, never from cmd_* ports.
REQ-017 In EXEC1, ADD SHALL drive A=a, B=b, Sel=SEL_ADD, capture xsum[31:0] to rsp_data and xsum[32] to rsp_carry, then go to RESP.
REQ-018 In EXEC1, MUL SHALL drive A=a, Sel=SEL_MUL, capture xprod to rsp_data, set rsp_carry=0, then go to RESP.
REQ-019 In EXEC1, MAC SHALL drive A=a, Sel=SEL_MUL, capture xprod into prod_q, then go to EXEC2.
REQ-020 In EXEC2 (MAC only), the block SHALL drive A=prod_q, B=acc_q, Sel=SEL_ADD, and set acc_q to xsum[31:0] and rsp_data to the same value, with rsp_carry=xsum[32]; it then goes to RESP.
REQ-021 With SAT_EN=1, when xsum[32]=1 in EXEC2, acc_q and rsp_data SHALL be 32'hFFFF_FFFF and rsp_carry SHALL be 1.
REQ-022 In EXEC1, LDACC SHALL set acc_q=a and rsp_data=a with rsp_carry=0, without using the ACU, then go to RESP.
REQ-023 In RESP, rsp_valid_o SHALL be 1, and rsp_data_o and rsp_carry_o SHALL be held stable until rsp_ready_i=1; the FSM then goes to IDLE.
REQ-024 Latency from the accept edge T SHALL be: rsp_valid_o high from T+2 for ADD, MUL and LDACC, and from T+3 for MAC.
REQ-025 A new command SHALL NOT be accepted in the cycle rsp handshake completes; throughput is one command per 3 cycles (4 for MAC).
REQ-026 acc_q SHALL change only in EXEC2 or on LDACC; ADD and MUL SHALL leave acc_q unchanged.
REQ-027 Accumulator wrap: with SAT_EN=0, the sum SHALL wrap modulo 2^32.
REQ-028 In states other than EXEC1/EXEC2, Sel SHALL be SEL_ADD and A/B SHALL be 0.

Reset
REQ-029 With rst_ni=0 at a clock edge, the block SHALL set: state=IDLE; acc_q, prod_q, rsp_data and latched operands to 0; rsp_carry=0.
REQ-030 During reset, rsp_valid_o=0, busy_o=0 and cmd_ready_o=0.
REQ-031 Reset asserted mid-operation SHALL discard the in-flight command and produce no response.

Structure
REQ-032 Package acu_pkg SHALL hold the opcode localparams, SEL_ADD (4'd0), SEL_MUL (4'd1), SEL_MAC (4'd4) and the FSM state encoding.
REQ-033 The single sub-module SHALL be the existing ACU instance; no other arithmetic is permitted beyond the saturation mux.

Verification (operands < 16 so ACU results are exact)
REQ-034 The bench SHALL check ADD with a=5, b=7: rsp_data=12, rsp_carry=0, rsp_valid at T+2.
REQ-035 The bench SHALL check MUL with a=3: rsp_data=9 at T+2, and acc_o unchanged.
REQ-036 The bench SHALL check LDACC a=10, then MAC a=3, then MAC a=2: rsp_data 10, 19, 23; acc_o=23; MAC rsp at T+3.
REQ-037 The bench SHALL check SAT_EN=1 with LDACC a=32'hFFFF_FFFE then MAC a=2: acc_o=32'hFFFF_FFFF, rsp_carry=1; with SAT_EN=0, acc_o=2, rsp_carry=1.
REQ-038 The bench SHALL check backpressure: hold rsp_ready_i=0 for 5 cycles after ADD; rsp_data stays stable, cmd_ready_o stays 0, and a pending cmd is accepted only after the response handshake.
REQ-039 The bench SHALL check reset during EXEC2 of a MAC: no response, acc_o=0, cmd_ready_o=1 in the first cycle after reset release.
